// File: rtl/avalon_crypto_ctrl_if.sv
// Avalon-MM slave bus bundle for the crypto controller: address/strobe/data
// from the host, read data and level interrupt back to it.
interface avalon_crypto_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  AVL_CS;
  logic                  AVL_READ;
  logic                  AVL_WRITE;
  logic [DATA_W/8-1:0]   AVL_BYTE_EN;
  logic [ADDR_W-1:0]     AVL_ADDR;
  logic [DATA_W-1:0]     AVL_WRITEDATA;
  logic [DATA_W-1:0]     AVL_READDATA;
  logic                  AVL_IRQ;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA, AVL_IRQ
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA, AVL_IRQ
  );
endinterface

// File: rtl/avalon_crypto_ctrl.sv
// Avalon-MM register file and run sequencer for a block-cipher core.
// Holds key/message words, launches the core with a START/DONE handshake,
// captures the result, counts run cycles, enforces a timeout and raises a
// maskable level interrupt when a run finishes or fails.
module avalon_crypto_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int KEY_WORDS = 4,
  parameter int BLK_WORDS = 4,
  parameter int READ_LAT  = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  avalon_crypto_ctrl_if.slave           avl,
  output logic [KEY_WORDS*DATA_W-1:0]   CORE_KEY,
  output logic [BLK_WORDS*DATA_W-1:0]   CORE_MSG,
  output logic                          CORE_START,
  input  logic                          CORE_DONE,
  input  logic [BLK_WORDS*DATA_W-1:0]   CORE_RESULT,
  output logic [DATA_W-1:0]             EXPORT_DATA
);

  localparam int NBYTE  = DATA_W / 8;
  localparam int KM_END = KEY_WORDS + BLK_WORDS;
  localparam logic [ADDR_W-1:0] A_CYC  = ADDR_W'(2**ADDR_W - 3);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2**ADDR_W - 2);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(2**ADDR_W - 1);
  // Last count value seen before the cycle that hits the timeout limit.
  localparam logic [DATA_W-1:0] TO_LAST = DATA_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t             state_q;
  logic               core_start_q;
  logic [DATA_W-1:0]  cycles_q;
  logic [DATA_W-1:0]  key_q [KEY_WORDS];
  logic [DATA_W-1:0]  msg_q [BLK_WORDS];
  logic [DATA_W-1:0]  res_q [BLK_WORDS];
  logic               ie_q, done_q, err_q, werr_q, irq_q;
  logic               ie_d, done_d, err_d, werr_d;

  logic               wr_en, rd_en, busy, km_hit;
  logic               ctrl_wr, stat_wr, start_req, abort_req, go;
  logic               to_hit, done_evt, err_evt;
  logic [DATA_W-1:0]  rd_mux;

  assign wr_en     = avl.AVL_CS && avl.AVL_WRITE;
  assign rd_en     = avl.AVL_CS && avl.AVL_READ;
  assign busy      = (state_q == S_RUN);
  assign km_hit    = (avl.AVL_ADDR < ADDR_W'(KM_END));
  // Control bits all live in byte 0, so that byte lane gates them.
  assign ctrl_wr   = wr_en && (avl.AVL_ADDR == A_CTRL) && avl.AVL_BYTE_EN[0];
  assign stat_wr   = wr_en && (avl.AVL_ADDR == A_STAT) && avl.AVL_BYTE_EN[0];
  assign start_req = ctrl_wr && avl.AVL_WRITEDATA[0];
  assign abort_req = ctrl_wr && avl.AVL_WRITEDATA[1];
  assign go        = start_req && !busy;
  assign to_hit    = (TIMEOUT != 0) && (cycles_q == TO_LAST);
  // Abort outranks a completing core, which outranks the timeout.
  assign done_evt  = busy && !abort_req && CORE_DONE;
  assign err_evt   = busy && !abort_req && !CORE_DONE && to_hit;

  // Next values of IE and the sticky status flags; hardware sets beat W1C.
  always_comb begin
    ie_d   = ctrl_wr ? avl.AVL_WRITEDATA[2] : ie_q;
    done_d = done_q;
    err_d  = err_q;
    werr_d = werr_q;
    if (stat_wr && avl.AVL_WRITEDATA[1]) done_d = 1'b0;
    if (stat_wr && avl.AVL_WRITEDATA[2]) err_d  = 1'b0;
    if (stat_wr && avl.AVL_WRITEDATA[3]) werr_d = 1'b0;
    if (done_evt) done_d = 1'b1;
    if (err_evt)  err_d  = 1'b1;
    if (wr_en && busy && km_hit) werr_d = 1'b1;
    if (go) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  // Flag and interrupt registers; IRQ follows the flags' next values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      werr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      done_q <= done_d;
      err_q  <= err_d;
      werr_q <= werr_d;
      irq_q  <= ie_d && (done_d || err_d);
    end
  end

  // Byte-enabled key/message writes, locked out while a run is active.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < BLK_WORDS; i++) msg_q[i] <= '0;
    end else if (wr_en && !busy) begin
      for (int i = 0; i < KEY_WORDS; i++)
        if (avl.AVL_ADDR == ADDR_W'(i))
          for (int b = 0; b < NBYTE; b++)
            if (avl.AVL_BYTE_EN[b]) key_q[i][8*b +: 8] <= avl.AVL_WRITEDATA[8*b +: 8];
      for (int i = 0; i < BLK_WORDS; i++)
        if (avl.AVL_ADDR == ADDR_W'(KEY_WORDS + i))
          for (int b = 0; b < NBYTE; b++)
            if (avl.AVL_BYTE_EN[b]) msg_q[i][8*b +: 8] <= avl.AVL_WRITEDATA[8*b +: 8];
    end
  end

  // Run sequencer: state, registered CORE_START, cycle counter, result capture.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      core_start_q <= 1'b0;
      cycles_q     <= '0;
      for (int i = 0; i < BLK_WORDS; i++) res_q[i] <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!(&cycles_q)) cycles_q <= cycles_q + DATA_W'(1);
          if (abort_req) begin
            state_q      <= S_IDLE;
            core_start_q <= 1'b0;
          end else if (CORE_DONE) begin
            state_q      <= S_DONE;
            core_start_q <= 1'b0;
            for (int i = 0; i < BLK_WORDS; i++)
              res_q[i] <= CORE_RESULT[(BLK_WORDS-1-i)*DATA_W +: DATA_W];
          end else if (to_hit) begin
            state_q      <= S_ERR;
            core_start_q <= 1'b0;
          end
        end
        default: begin
          if (start_req) begin
            state_q      <= S_RUN;
            core_start_q <= 1'b1;
            cycles_q     <= '0;
          end
        end
      endcase
    end
  end

  // Read decode from current register contents; unmapped slots read zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      if (avl.AVL_ADDR == ADDR_W'(i)) rd_mux = key_q[i];
    for (int i = 0; i < BLK_WORDS; i++)
      if (avl.AVL_ADDR == ADDR_W'(KEY_WORDS + i)) rd_mux = msg_q[i];
    for (int i = 0; i < BLK_WORDS; i++)
      if (avl.AVL_ADDR == ADDR_W'(KM_END + i)) rd_mux = res_q[i];
    if (avl.AVL_ADDR == A_CYC)  rd_mux = cycles_q;
    if (avl.AVL_ADDR == A_CTRL) rd_mux = DATA_W'({ie_q, 2'b00});
    if (avl.AVL_ADDR == A_STAT) rd_mux = DATA_W'({werr_q, err_q, done_q, busy});
  end

  if (READ_LAT == 1) begin : g_rd_reg
    logic [DATA_W-1:0] rdata_q;
    // Registered read data, held between reads.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)   rdata_q <= '0;
      else if (rd_en) rdata_q <= rd_mux;
    end
    assign avl.AVL_READDATA = rdata_q;
  end else begin : g_rd_comb
    assign avl.AVL_READDATA = rd_en ? rd_mux : '0;
  end

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key_out
    assign CORE_KEY[(KEY_WORDS-1-i)*DATA_W +: DATA_W] = key_q[i];
  end
  for (genvar i = 0; i < BLK_WORDS; i++) begin : g_msg_out
    assign CORE_MSG[(BLK_WORDS-1-i)*DATA_W +: DATA_W] = msg_q[i];
  end

  assign CORE_START  = core_start_q;
  assign avl.AVL_IRQ = irq_q;
  assign EXPORT_DATA = {res_q[0][DATA_W-1 -: DATA_W/2], res_q[BLK_WORDS-1][DATA_W/2-1:0]};

endmodule

// File: tb/tb_avalon_crypto_ctrl.sv
// Bench for avalon_crypto_ctrl: two instances (registered and combinational
// read data) share one Avalon stimulus stream and one stub cipher core.
module tb_avalon_crypto_ctrl;

  logic clk, rst_n;
  logic core_done, stub_done, manual_done, stub_en;
  int   stub_lat, stub_cnt;
  logic [127:0] core_result;
  logic [127:0] core_key, core_msg, core_key0, core_msg0;
  logic         core_start, core_start0;
  logic [31:0]  export_data, export_data0;

  int n_checks, n_fail;

  logic [31:0] m_mem [16];
  logic [31:0] m_cycles;
  logic        m_ie;
  logic [3:0]  m_stat;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [19];

  avalon_crypto_ctrl_if #(.DATA_W(32), .ADDR_W(4)) if1 ();
  avalon_crypto_ctrl_if #(.DATA_W(32), .ADDR_W(4)) if0 ();

  assign if0.AVL_CS        = if1.AVL_CS;
  assign if0.AVL_READ      = if1.AVL_READ;
  assign if0.AVL_WRITE     = if1.AVL_WRITE;
  assign if0.AVL_BYTE_EN   = if1.AVL_BYTE_EN;
  assign if0.AVL_ADDR      = if1.AVL_ADDR;
  assign if0.AVL_WRITEDATA = if1.AVL_WRITEDATA;
  assign core_done = stub_done | manual_done;

  avalon_crypto_ctrl #(.READ_LAT(1)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .avl(if1),
    .CORE_KEY(core_key), .CORE_MSG(core_msg), .CORE_START(core_start),
    .CORE_DONE(core_done), .CORE_RESULT(core_result), .EXPORT_DATA(export_data)
  );

  avalon_crypto_ctrl #(.READ_LAT(0)) u_dut0 (
    .CLK(clk), .RESET_N(rst_n), .avl(if0),
    .CORE_KEY(core_key0), .CORE_MSG(core_msg0), .CORE_START(core_start0),
    .CORE_DONE(core_done), .CORE_RESULT(core_result), .EXPORT_DATA(export_data0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: answers in the stub_lat-th cycle of CORE_START.
  always @(negedge clk) begin
    if (core_start) begin
      stub_cnt  <= stub_cnt + 1;
      stub_done <= stub_en && (stub_cnt + 1 == stub_lat);
    end else begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic avl_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    if1.AVL_CS = 1'b1; if1.AVL_WRITE = 1'b1; if1.AVL_ADDR = a;
    if1.AVL_WRITEDATA = d; if1.AVL_BYTE_EN = be;
    @(negedge clk);
    if1.AVL_CS = 1'b0; if1.AVL_WRITE = 1'b0; if1.AVL_BYTE_EN = 4'h0;
  endtask

  task automatic avl_read(input logic [3:0] a, output logic [31:0] d1, output logic [31:0] d0);
    if1.AVL_CS = 1'b1; if1.AVL_READ = 1'b1; if1.AVL_ADDR = a;
    #1 d0 = if0.AVL_READDATA;
    @(posedge clk);
    #1 d1 = if1.AVL_READDATA;
    @(negedge clk);
    if1.AVL_CS = 1'b0; if1.AVL_READ = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d1, d0;
    avl_read(a, d1, d0);
    check({nm, "_rl1"}, d1, exp);
    check({nm, "_rl0"}, d0, exp);
  endtask

  task automatic run_wait(input int maxc, output int hi);
    hi = 0;
    while (core_start && hi < maxc) begin
      hi++;
      @(negedge clk);
    end
    check("run_ended", core_start, 1'b0);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < 12)  return m_mem[a];
    if (a == 13) return m_cycles;
    if (a == 14) return {29'd0, m_ie, 2'b00};
    if (a == 15) return {28'd0, m_stat};
    return 32'd0;
  endfunction

  task automatic set_res(input logic [127:0] r);
    for (int w = 0; w < 4; w++) m_mem[8+w] = r[(3-w)*32 +: 32];
  endtask

  initial begin
    logic [127:0] r1, rr;
    logic [31:0]  d1, d0, d;
    logic [3:0]   a, be;
    int hi, lat, op;

    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; manual_done = 1'b0; stub_en = 1'b0; stub_lat = 0;
    core_result = '0;
    if1.AVL_CS = 0; if1.AVL_READ = 0; if1.AVL_WRITE = 0;
    if1.AVL_BYTE_EN = 0; if1.AVL_ADDR = 0; if1.AVL_WRITEDATA = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_cycles = '0; m_ie = 1'b0; m_stat = 4'h0;
    r1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    tbl[0]  = '{4'd0,  32'h00010203, 4'hF, 32'h00010203};
    tbl[1]  = '{4'd1,  32'h04050607, 4'hF, 32'h04050607};
    tbl[2]  = '{4'd2,  32'h08090A0B, 4'hF, 32'h08090A0B};
    tbl[3]  = '{4'd3,  32'h0C0D0E0F, 4'hF, 32'h0C0D0E0F};
    tbl[4]  = '{4'd4,  32'hDAEC3055, 4'hF, 32'hDAEC3055};
    tbl[5]  = '{4'd5,  32'hDF058E1C, 4'hF, 32'hDF058E1C};
    tbl[6]  = '{4'd6,  32'h39E814EA, 4'hF, 32'h39E814EA};
    tbl[7]  = '{4'd7,  32'h76F6747E, 4'hF, 32'h76F6747E};
    tbl[8]  = '{4'd0,  32'hFFFFFFFF, 4'h5, 32'h00FF02FF};
    tbl[9]  = '{4'd0,  32'h00010203, 4'hF, 32'h00010203};
    tbl[10] = '{4'd12, 32'hDEADBEEF, 4'hF, 32'h00000000};
    tbl[11] = '{4'd8,  32'h12345678, 4'hF, 32'h00000000};
    tbl[12] = '{4'd13, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    tbl[13] = '{4'd14, 32'h00000004, 4'hF, 32'h00000004};
    tbl[14] = '{4'd14, 32'h000000FF, 4'hE, 32'h00000004};
    tbl[15] = '{4'd14, 32'h00000000, 4'hF, 32'h00000000};
    tbl[16] = '{4'd15, 32'h0000000F, 4'hF, 32'h00000000};
    tbl[17] = '{4'd6,  32'hFFFF0000, 4'hC, 32'hFFFF14EA};
    tbl[18] = '{4'd6,  32'h39E814EA, 4'hF, 32'h39E814EA};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_core_start", core_start, 1'b0);
    check("rst_irq", if1.AVL_IRQ, 1'b0);
    check("rst_export", export_data, 32'h0);
    rd_chk("rst_status", 4'd15, 32'h0);
    rd_chk("rst_cycles", 4'd13, 32'h0);
    rd_chk("rst_ctrl", 4'd14, 32'h0);

    // Register map vectors
    for (int i = 0; i < 19; i++) begin
      avl_write(tbl[i].a, tbl[i].d, tbl[i].be);
      if (tbl[i].a < 8) m_mem[tbl[i].a] = merge(m_mem[tbl[i].a], tbl[i].d, tbl[i].be);
      rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
    end
    check("core_key", core_key, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    check("core_msg", core_msg, 128'hDAEC3055_DF058E1C_39E814EA_76F6747E);

    // Read and write of the same address in one cycle returns the old value
    if1.AVL_CS = 1; if1.AVL_READ = 1; if1.AVL_WRITE = 1; if1.AVL_ADDR = 4'd2;
    if1.AVL_WRITEDATA = 32'hA5A5A5A5; if1.AVL_BYTE_EN = 4'hF;
    #1 d0 = if0.AVL_READDATA;
    @(posedge clk);
    #1 d1 = if1.AVL_READDATA;
    @(negedge clk);
    if1.AVL_CS = 0; if1.AVL_READ = 0; if1.AVL_WRITE = 0; if1.AVL_BYTE_EN = 0;
    check("rw_same_rl1", d1, 32'h08090A0B);
    check("rw_same_rl0", d0, 32'h08090A0B);
    m_mem[2] = 32'hA5A5A5A5;
    rd_chk("rw_new", 4'd2, m_mem[2]);
    @(negedge clk);
    check("rd_hold", if1.AVL_READDATA, m_mem[2]);

    // Basic run, core answers after 10 cycles
    core_result = r1; stub_lat = 10; stub_en = 1'b1;
    avl_write(4'd14, 32'h1, 4'hF);
    run_wait(200, hi);
    check("run1_start_cycles", hi, 10);
    set_res(r1);
    for (int w = 0; w < 4; w++) rd_chk($sformatf("run1_res%0d", w), 4'(8 + w), m_mem[8+w]);
    rd_chk("run1_status", 4'd15, 32'h2);
    rd_chk("run1_cycles", 4'd13, 32'd10);
    check("run1_export", export_data, {r1[127:112], r1[15:0]});
    check("run1_irq_masked", if1.AVL_IRQ, 1'b0);

    // Interrupt and repeated START
    avl_write(4'd15, 32'h2, 4'hF);
    stub_lat = 6;
    avl_write(4'd14, 32'h5, 4'hF);
    check("irq_during_run", if1.AVL_IRQ, 1'b0);
    run_wait(200, hi);
    check("irq_set", if1.AVL_IRQ, 1'b1);
    check("irq_set_rl0", if0.AVL_IRQ, 1'b1);
    avl_write(4'd15, 32'h2, 4'hF);
    check("irq_cleared", if1.AVL_IRQ, 1'b0);
    avl_write(4'd14, 32'h5, 4'hF);
    check("restart_start", core_start, 1'b1);
    run_wait(200, hi);
    check("restart_cycles", hi, 6);

    // Busy write-lock
    stub_lat = 12;
    avl_write(4'd14, 32'h5, 4'hF);
    avl_write(4'd5, 32'h12345678, 4'hF);
    rd_chk("lock_status_busy", 4'd15, 32'h9);
    run_wait(200, hi);
    rd_chk("lock_msg1", 4'd5, m_mem[5]);
    rd_chk("lock_status_done", 4'd15, 32'hA);
    avl_write(4'd15, 32'h8, 4'hF);
    rd_chk("lock_werr_clr", 4'd15, 32'h2);

    // Timeout with a silent core
    stub_en = 1'b0;
    avl_write(4'd15, 32'h2, 4'hF);
    avl_write(4'd14, 32'h5, 4'hF);
    run_wait(1100, hi);
    check("to_start_cycles", hi, 1023);
    check("to_core_start", core_start, 1'b0);
    check("to_irq", if1.AVL_IRQ, 1'b1);
    rd_chk("to_status", 4'd15, 32'h4);
    rd_chk("to_cycles", 4'd13, 32'd1023);
    rd_chk("to_res0", 4'd8, m_mem[8]);

    // Abort in the fifth run cycle
    avl_write(4'd14, 32'h5, 4'hF);
    repeat (4) @(negedge clk);
    avl_write(4'd14, 32'h6, 4'hF);
    check("abort_core_start", core_start, 1'b0);
    check("abort_irq", if1.AVL_IRQ, 1'b0);
    rd_chk("abort_status", 4'd15, 32'h0);
    rd_chk("abort_cycles", 4'd13, 32'd5);

    // CORE_DONE and ABORT in the same cycle: abort wins
    avl_write(4'd14, 32'h5, 4'hF);
    repeat (2) @(negedge clk);
    manual_done = 1'b1;
    avl_write(4'd14, 32'h6, 4'hF);
    manual_done = 1'b0;
    check("dab_core_start", core_start, 1'b0);
    rd_chk("dab_status", 4'd15, 32'h0);
    rd_chk("dab_cycles", 4'd13, 32'd3);
    rd_chk("dab_res3", 4'd11, m_mem[11]);

    // CORE_DONE outside RUN is ignored
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    rd_chk("idle_done_status", 4'd15, 32'h0);
    rd_chk("idle_done_res0", 4'd8, m_mem[8]);

    // Randomized accesses and runs against the reference model
    m_cycles = 32'd3; m_ie = 1'b1; m_stat = 4'h0;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = 4'($urandom_range(0, 7)); d = $urandom; be = 4'($urandom_range(0, 15));
        avl_write(a, d, be);
        m_mem[a] = merge(m_mem[a], d, be);
        rd_chk("rnd_wr", a, m_mem[a]);
      end else if (op == 1) begin
        a = 4'($urandom_range(0, 15));
        rd_chk("rnd_rd", a, m_read(int'(a)));
      end else begin
        lat = $urandom_range(1, 40);
        rr = {$urandom, $urandom, $urandom, $urandom};
        core_result = rr; stub_lat = lat; stub_en = 1'b1;
        avl_write(4'd14, {29'd0, m_ie, 2'b01}, 4'hF);
        run_wait(200, hi);
        check("rnd_run_cycles", hi, lat);
        set_res(rr);
        m_cycles = 32'(lat); m_stat = 4'h2;
        for (int w = 0; w < 4; w++) rd_chk("rnd_res", 4'(8 + w), m_mem[8+w]);
        rd_chk("rnd_status", 4'd15, {28'd0, m_stat});
        rd_chk("rnd_cycles", 4'd13, m_cycles);
        check("rnd_export", export_data, {rr[127:112], rr[15:0]});
        check("rnd_irq", if1.AVL_IRQ, m_ie);
      end
    end
    check("rnd_core_key", core_key, {m_mem[0], m_mem[1], m_mem[2], m_mem[3]});
    check("rnd_core_msg", core_msg, {m_mem[4], m_mem[5], m_mem[6], m_mem[7]});

    // Asynchronous reset in the middle of a run
    stub_en = 1'b0;
    avl_write(4'd14, 32'h5, 4'hF);
    repeat (3) @(negedge clk);
    check("pre_rst_start", core_start, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_core_start", core_start, 1'b0);
    check("arst_core_start0", core_start0, 1'b0);
    check("arst_irq", if1.AVL_IRQ, 1'b0);
    check("arst_key", core_key, 128'h0);
    check("arst_msg", core_msg, 128'h0);
    check("arst_key0", core_key0, 128'h0);
    check("arst_msg0", core_msg0, 128'h0);
    check("arst_export", export_data, 32'h0);
    check("arst_export0", export_data0, 32'h0);
    check("arst_rdata", if1.AVL_READDATA, 32'h0);
    check("arst_rdata0", if0.AVL_READDATA, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_status", 4'd15, 32'h0);
    rd_chk("post_rst_key0", 4'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
